ofdm_cp_remover: RTL

OFDM_CP_REMOVER -- requirements
Module: ofdm_cp_remover

---
 rtl/ofdm_cp_remover.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ofdm_cp_remover.sv
// Cyclic-prefix remover for framed OFDM sample streams: skips cp_len samples,
// passes sym_len samples per symbol, optionally drops after num_syms symbols.
module ofdm_cp_remover #(
    parameter int BASE  = 0,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             eob,
    output logic [15:0]      sym_cnt
);

    localparam logic [1:0] SKIP = 2'd0;
    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [7:0] ADDR_LEN = 8'(BASE);
    localparam logic [7:0] ADDR_NUM = 8'(BASE + 1);

    logic [15:0] sym_len_reg, cp_len_reg, num_syms_reg;
    logic [15:0] sym_len_act, cp_len_act, num_syms_act;
    logic [15:0] sym_len_eff, cp_len_eff, num_syms_eff;
    logic [15:0] last_smp;
    logic [15:0] cp_cnt, smp_cnt;
    logic [16:0] sym_cnt_inc;
    logic [1:0]  state, cur_state, home_state;
    logic        fresh;
    logic        in_pass, accept, quota_hit;

    // NOTE: settings are plain registers, so they take a reset value like any other flop.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sym_len_reg  <= 16'd64;
            cp_len_reg   <= 16'd16;
            num_syms_reg <= 16'd0;
        end else if (set_stb) begin
            if (set_addr == ADDR_LEN) begin
                sym_len_reg <= set_data[15:0];
                cp_len_reg  <= set_data[31:16];
            end else if (set_addr == ADDR_NUM) begin
                num_syms_reg <= set_data[15:0];
            end
        end
    end

    // Until the first beat of a burst is accepted the live registers are in force,
    // so the burst-start state always reflects the settings written before it.
    always_comb begin
        sym_len_eff  = fresh ? sym_len_reg  : sym_len_act;
        cp_len_eff   = fresh ? cp_len_reg   : cp_len_act;
        num_syms_eff = fresh ? num_syms_reg : num_syms_act;
        last_smp     = (sym_len_eff == 16'd0) ? 16'd0 : sym_len_eff - 16'd1;
        home_state   = (cp_len_eff == 16'd0) ? PASS : SKIP;
        cur_state    = fresh ? home_state : state;
        in_pass      = (cur_state == PASS);
        i_tready     = in_pass ? o_tready : 1'b1;
        o_tvalid     = in_pass & i_tvalid;
        o_tdata      = i_tdata;
        o_tlast      = in_pass & (i_tlast | (smp_cnt == last_smp));
        accept       = i_tvalid & i_tready;
        sym_cnt_inc  = {1'b0, sym_cnt} + 17'd1;
        quota_hit    = (num_syms_eff != 16'd0) && (sym_cnt_inc == {1'b0, num_syms_eff});
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            fresh        <= 1'b1;
            state        <= SKIP;
            cp_cnt       <= 16'd0;
            smp_cnt      <= 16'd0;
            sym_cnt      <= 16'd0;
            eob          <= 1'b0;
            sym_len_act  <= 16'd64;
            cp_len_act   <= 16'd16;
            num_syms_act <= 16'd0;
        end else if (clear) begin
            fresh   <= 1'b1;
            state   <= SKIP;
            cp_cnt  <= 16'd0;
            smp_cnt <= 16'd0;
            sym_cnt <= 16'd0;
            eob     <= 1'b0;
        end else begin
            eob <= accept & i_tlast;
            if (accept) begin
                if (fresh) begin
                    sym_len_act  <= sym_len_reg;
                    cp_len_act   <= cp_len_reg;
                    num_syms_act <= num_syms_reg;
                end
                if (i_tlast) begin
                    fresh   <= 1'b1;
                    state   <= SKIP;
                    cp_cnt  <= 16'd0;
                    smp_cnt <= 16'd0;
                    sym_cnt <= 16'd0;
                end else begin
                    fresh <= 1'b0;
                    case (cur_state)
                        SKIP: begin
                            if (cp_cnt == cp_len_eff - 16'd1) begin
                                state  <= PASS;
                                cp_cnt <= 16'd0;
                            end else begin
                                state  <= SKIP;
                                cp_cnt <= cp_cnt + 16'd1;
                            end
                        end
                        PASS: begin
                            if (smp_cnt == last_smp) begin
                                smp_cnt <= 16'd0;
                                if (sym_cnt != 16'hFFFF) sym_cnt <= sym_cnt_inc[15:0];
                                state <= quota_hit ? DROP : home_state;
                            end else begin
                                state   <= PASS;
                                smp_cnt <= smp_cnt + 16'd1;
                            end
                        end
                        default: state <= DROP;
                    endcase
                end
            end
        end
    end

endmodule
